// File: rtl/div23_pkg.sv
// Shared constants, beat types and helpers for the exact divide-by-23 quotient stage.
//
// Contents:
//   W_X, W_R, W_Q  - dividend, remainder and quotient widths
//   DIVISOR        - the constant divisor (23)
//   INV_23_16      - 23^-1 mod 2^16; 23 * 0x37A7 = 327681 = 5 * 2^16 + 1
//   div23_beat_t   - input beat {x, r}
//   div23_res_t    - result beat {q, r}
//   div23_mul_inv  - (d * INV_23_16) mod 2^W_X
package div23_pkg;

  localparam int unsigned W_X     = 16;
  localparam int unsigned W_R     = 5;
  localparam int unsigned W_Q     = 12;
  localparam int unsigned DIVISOR = 23;

  localparam logic [W_X-1:0] INV_23_16 = 16'h37A7;

  typedef struct packed {
    logic [W_X-1:0] x;
    logic [W_R-1:0] r;
  } div23_beat_t;

  typedef struct packed {
    logic [W_Q-1:0] q;
    logic [W_R-1:0] r;
  } div23_res_t;

  // Exact division of a known multiple of 23: multiplying by the modular inverse
  // modulo 2^W_X recovers the quotient in the low bits with no remainder logic.
  function automatic logic [W_X-1:0] div23_mul_inv(input logic [W_X-1:0] d);
    logic [W_X-1:0] p;
    p = d * INV_23_16;
    return p;
  endfunction

endpackage

// File: rtl/div23_pipe_stage.sv
// Generic valid/ready register slice.
//
// A single register with a valid bit. The slice accepts a new beat whenever it is
// empty or its current beat leaves in the same cycle, so back-to-back stages run at
// one beat per cycle and an empty slice fills even while the consumer stalls.
// in_ready_o depends combinationally on out_ready_i.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset (clears valid and data)
//   in_valid_i   upstream beat valid
//   in_ready_o   slice can take a beat this cycle
//   in_data_i    upstream payload
//   out_valid_o  slice holds a beat
//   out_ready_i  downstream takes the beat
//   out_data_o   held payload, stable while out_valid_o && !out_ready_i
module div23_pipe_stage #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;
  logic             load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // While the slice can move, its next valid is simply whether a beat arrives.
      if (in_ready_o) begin
        valid_q <= in_valid_i;
      end
      if (load) begin
        data_q <= in_data_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/div_16_23_quot.sv
// Quotient stage after the mod-23 residue unit: Q = (X - R) / 23 for a 16-bit X.
//
// Two register slices:
//   S1 holds d = X - R (mod 2^16) and R.
//   S2 holds Q = low 12 bits of (d * 23^-1 mod 2^16) and R.
// Latency is 2 cycles from input handshake to out_valid; throughput 1 beat/cycle.
// R passes through so the consumer sees {Q, R} as one beat.
//
// Optional build macro DIV23Q_SELFCHECK_EN: S1 also carries X, and S2 registers
// err = (Q*23 + R != X) || (R >= 23). Without it err is tied 0 and X is dropped.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset; discards in-flight beats
//   in_valid   input beat valid
//   in_ready   stage can accept a beat (combinational from out_ready)
//   in_x       dividend X
//   in_r       remainder X mod 23
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_q      quotient
//   out_r      remainder, passed through
//   err        self-check failure, valid with out_valid
module div_16_23_quot
  import div23_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_X-1:0] in_x,
  input  logic [W_R-1:0] in_r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_Q-1:0] out_q,
  output logic [W_R-1:0] out_r,
  output logic           err
);

`ifdef DIV23Q_SELFCHECK_EN
  typedef struct packed {
    logic [W_X-1:0] d;
    logic [W_R-1:0] r;
    logic [W_X-1:0] x;
  } s1_t;

  typedef struct packed {
    div23_res_t res;
    logic       err;
  } s2_t;
`else
  typedef struct packed {
    logic [W_X-1:0] d;
    logic [W_R-1:0] r;
  } s1_t;

  typedef struct packed {
    div23_res_t res;
  } s2_t;
`endif

  div23_beat_t in_beat;
  s1_t         s1_in;
  s1_t         s1_out;
  s2_t         s2_in;
  s2_t         s2_out;
  logic        s1_valid;
  logic        s2_in_ready;

  assign in_beat = '{x: in_x, r: in_r};

  // Stage 1 input: subtract the remainder so the value is an exact multiple of 23.
  always_comb begin
    s1_in   = '0;
    s1_in.d = in_beat.x - W_X'(in_beat.r);
    s1_in.r = in_beat.r;
`ifdef DIV23Q_SELFCHECK_EN
    s1_in.x = in_beat.x;
`endif
  end

  div23_pipe_stage #(
    .Width($bits(s1_t))
  ) u_s1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (s1_in),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_in_ready),
    .out_data_o (s1_out)
  );

`ifdef DIV23Q_SELFCHECK_EN
  localparam int unsigned W_RC = W_X + 1;

  // Reconstruct X from the computed quotient; 17 bits since a wrong q can overflow 16.
  logic [W_RC-1:0] recon;
`endif

  // Stage 2 input: modular-inverse multiply. For in-contract beats the product is
  // below 2^12, so only the low W_Q bits are kept.
  always_comb begin
    s2_in       = '0;
    s2_in.res.q = W_Q'(div23_mul_inv(s1_out.d));
    s2_in.res.r = s1_out.r;
`ifdef DIV23Q_SELFCHECK_EN
    recon     = W_RC'(s2_in.res.q) * W_RC'(DIVISOR) + W_RC'(s1_out.r);
    s2_in.err = (recon != W_RC'(s1_out.x)) || (s1_out.r >= W_R'(DIVISOR));
`endif
  end

  div23_pipe_stage #(
    .Width($bits(s2_t))
  ) u_s2 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_in_ready),
    .in_data_i  (s2_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (s2_out)
  );

  assign out_q = s2_out.res.q;
  assign out_r = s2_out.res.r;

`ifdef DIV23Q_SELFCHECK_EN
  assign err = s2_out.err;
`else
  assign err = 1'b0;
`endif

endmodule
